mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDRESS_BITS, default 16, SHALL set the memory address width.
REQ-002 Parameter STREAK_MAX, default 4, SHALL set the maximum number of consecutive data grants while fetch waits.
REQ-003 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 if_req  in  1  SHALL be the instruction-fetch request, held high until if_done.
REQ-006 if_addr  in  ADDRESS_BITS  SHALL be the fetch address, stable while if_req is high.
REQ-007 if_done  out  1  SHALL be a one-cycle pulse when the fetch read completes.
REQ-008 if_rdata  out  32  SHALL be the fetched instruction word.
REQ-009 d_req  in  1  SHALL be the load/store request, held high until d_done.
REQ-010 d_wEn  in  1  SHALL select the access type: 1 is store, 0 is load.
REQ-011 d_addr  in  ADDRESS_BITS  SHALL be the data address.
REQ-012 d_wdata  in  32  SHALL be the store data.
REQ-013 d_done  out  1  SHALL be a one-cycle pulse when the data access completes.
REQ-014 d_rdata  out  32  SHALL be the load result.
REQ-015 mem_req  out  1  SHALL signal a valid memory access.
REQ-016 mem_wEn, mem_addr, mem_wdata  out  1/ADDRESS_BITS/32  SHALL form the memory command.
REQ-017 mem_rdata  in  32, mem_ready  in  1  SHALL form the memory response; mem_ready may arrive after 1 to N cycles.
REQ-018 busy  out  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-019 FSM states SHALL be IDLE, BUSY_I and BUSY_D.
REQ-020 In IDLE with any request, the FSM SHALL pick a winner, latch its address, wEn and wdata into command registers, and enter BUSY_I or BUSY_D on the next edge.
REQ-021 Arbitration SHALL give d_req priority, unless if_req is high and streak equals STREAK_MAX, in which case fetch wins.
REQ-022 streak (width clog2(STREAK_MAX+1)) SHALL update on each grant:
- increments on a data grant with if_req high;
- clears on a data grant with if_req low;
- clears on any fetch grant;
- saturates at STREAK_MAX.
REQ-023 mem_req SHALL be high exactly while in BUSY_I or BUSY_D; mem_addr, mem_wEn and mem_wdata SHALL come from the command registers and stay stable throughout.
REQ-024 In BUSY_I, mem_wEn SHALL be 0 and mem_wdata SHALL be 0.
REQ-025 In BUSY_x with mem_ready high, the FSM SHALL complete the access on that edge:
- register x_done=1 for exactly one cycle;
- return to IDLE.
REQ-026 On completion, if_rdata SHALL capture mem_rdata for fetches, and d_rdata SHALL capture mem_rdata for loads only; stores leave d_rdata unchanged.
REQ-027 Minimum latency SHALL be: request seen at edge 0, mem_req high in cycle 1, mem_ready in cycle 1 gives x_done in cycle 2. The FSM spends at least one cycle in IDLE between accesses.
REQ-028 mem_ready in IDLE SHALL be ignored.
REQ-029 If a requester drops req while its access is in flight, the access SHALL still complete and x_done SHALL still pulse.
REQ-030 A request still high in the cycle x_done pulses SHALL be treated as a new request in IDLE; requesters drop req on done.
REQ-031 Simultaneous if_req and d_req in IDLE SHALL be resolved by REQ-021 only; the loser is held off and served in a later IDLE cycle.
REQ-032 if_done and d_done SHALL never be high in the same cycle.

Reset
REQ-033 Asserting reset low SHALL immediately force the following, with no further memory activity:
- FSM to IDLE;
- mem_req, mem_wEn, if_done, d_done and busy to 0;
- streak, the command registers, if_rdata and d_rdata to 0.
REQ-034 Reset during BUSY SHALL abandon the in-flight access: no done pulse, and a later mem_ready is ignored.
REQ-035 Release of reset SHALL take effect synchronously; the first arbitration happens on the first rising edge after release.

Verification
REQ-036 Lone fetch: if_req=1, if_addr=0x0010, mem_ready after 2 cycles with mem_rdata=0x00500093 -> mem_req for 2 cycles, if_done single pulse, if_rdata=0x00500093.
REQ-037 Store: d_req=1, d_wEn=1, d_addr=0x0100, d_wdata=0xDEADBEEF -> mem_wEn=1 with that address and data; d_done pulse; d_rdata unchanged.
REQ-038 Contention with STREAK_MAX=4, both requesters always re-requesting, mem_ready 1 cycle -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-039 Simultaneous single requests -> data served first, fetch next; no cycle has both done signals high.
REQ-040 Reset low during BUSY_D, mem_ready asserted after release -> no d_done, mem_req=0, FSM in IDLE, d_rdata=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester and a
//   load/store requester. Data requests normally win; after STREAK_MAX
//   consecutive data grants while fetch is waiting, fetch gets the next slot.
//   Each access is latched into command registers, held on the memory port
//   until mem_ready, then completed with a one-cycle done pulse. The FSM always
//   passes through IDLE between accesses.
//
// Ports
//   clock, reset          single clock, asynchronous active-low reset
//   if_req/if_addr        fetch request (held until if_done) and address
//   if_done/if_rdata      fetch completion pulse and fetched word
//   d_req/d_wEn/d_addr/d_wdata  load/store request (wEn=1 store)
//   d_done/d_rdata        data completion pulse and load result
//   mem_req/mem_wEn/mem_addr/mem_wdata  memory command
//   mem_rdata/mem_ready   memory response (ready after 1..N cycles)
//   busy                  high whenever the FSM is not in IDLE
module mem_port_arbiter #(
  parameter int ADDRESS_BITS = 16,
  parameter int STREAK_MAX   = 4    // must be >= 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDRESS_BITS-1:0] if_addr,
  output logic                    if_done,
  output logic [31:0]             if_rdata,
  input  logic                    d_req,
  input  logic                    d_wEn,
  input  logic [ADDRESS_BITS-1:0] d_addr,
  input  logic [31:0]             d_wdata,
  output logic                    d_done,
  output logic [31:0]             d_rdata,
  output logic                    mem_req,
  output logic                    mem_wEn,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ready,
  output logic                    busy
);

  localparam int STREAK_W = $clog2(STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STREAK_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state, state_nxt;

  logic                    grant_i, grant_d;  // arbitration result in IDLE
  logic                    cpl_i, cpl_d;      // access completes on this edge
  logic [STREAK_W-1:0]     streak;
  logic [ADDRESS_BITS-1:0] cmd_addr;
  logic                    cmd_wen;
  logic [31:0]             cmd_wdata;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, grant and completion strobes
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    cpl_i     = 1'b0;
    cpl_d     = 1'b0;
    case (state)
      IDLE: begin
        // Fetch only beats a pending data request once the streak is full.
        if (if_req && (!d_req || streak == STREAK_TOP)) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          cpl_i     = 1'b1;
          state_nxt = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          cpl_d     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command registers, streak counter, done pulses and read-data capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      streak    <= '0;
      cmd_addr  <= '0;
      cmd_wen   <= 1'b0;
      cmd_wdata <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_done <= cpl_i;
      d_done  <= cpl_d;

      if (grant_i) begin
        // Fetches are always reads; zero wdata keeps the bus quiet.
        cmd_addr  <= if_addr;
        cmd_wen   <= 1'b0;
        cmd_wdata <= '0;
        streak    <= '0;
      end

      if (grant_d) begin
        cmd_addr  <= d_addr;
        cmd_wen   <= d_wEn;
        cmd_wdata <= d_wdata;
        // Count only data grants that made fetch wait; saturate at the top.
        if (!if_req)                  streak <= '0;
        else if (streak != STREAK_TOP) streak <= streak + 1'b1;
      end

      if (cpl_i)             if_rdata <= mem_rdata;
      if (cpl_d && !cmd_wen) d_rdata  <= mem_rdata;
    end
  end

  assign mem_req   = (state != IDLE);
  assign busy      = (state != IDLE);
  assign mem_addr  = cmd_addr;
  assign mem_wEn   = cmd_wen;
  assign mem_wdata = cmd_wdata;

endmodule
